dmem_arbiter: RTL and testbench

- Shares the single-port data RAM (12-bit address, 32-bit data, synchronous read) between the processor's data-memory port and the FFT coprocessor's load/store port.
- Sits between processor/FFT engine and the RAM instance in the top-level wrapper.
- Grants one access per cycle with round-robin fairness, and routes read data back to the owner one cycle later.
- Supports a bounded FFT lock so a butterfly read-read-write-write sequence is not interleaved with CPU accesses.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arbiter_if.sv | 57 +++++
 rtl/dmem_arb_rr.sv | 76 +++++++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants and types for the data-memory arbiter
//
// Holds the arbiter state encoding (ARB/LOCK), the read-owner encoding
// (OWN_CPU/OWN_FFT), the default widths and the read-return tag type.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF   = 12;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_LOCK_DEF = 8;

    // Lock counter covers the full MAX_LOCK range of 1..255.
    localparam int LOCK_CNT_W = 8;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_FFT = 1'b1;

    // Read-return pipeline entry: a read was granted last cycle, and by whom.
    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bus bundle between CPU/FFT requesters, arbiter and RAM
//
// Signals:
//   cpu_req/cpu_wren/cpu_addr/cpu_wdata   CPU request and attributes
//   cpu_gnt/cpu_rvalid/cpu_rdata          CPU grant and read return
//   fft_req/fft_wren/fft_addr/fft_wdata   FFT request and attributes
//   fft_lock                              FFT exclusive-ownership request
//   fft_gnt/fft_rvalid/fft_rdata          FFT grant and read return
//   ram_wEn/ram_addr/ram_dataIn           RAM command (arbiter output)
//   ram_dataOut                           RAM read data, one cycle after address
// Modports: slave = arbiter side, master = requester/RAM side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = dmem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = dmem_arb_pkg::DATA_W_DEF
) ();

    logic              cpu_req;
    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              fft_req;
    logic              fft_wren;
    logic [ADDR_W-1:0] fft_addr;
    logic [DATA_W-1:0] fft_wdata;
    logic              fft_lock;
    logic              fft_gnt;
    logic              fft_rvalid;
    logic [DATA_W-1:0] fft_rdata;

    logic              ram_wEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dataIn;
    logic [DATA_W-1:0] ram_dataOut;

    modport slave (
        input  cpu_req, cpu_wren, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  fft_req, fft_wren, fft_addr, fft_wdata, fft_lock,
        output fft_gnt, fft_rvalid, fft_rdata,
        output ram_wEn, ram_addr, ram_dataIn,
        input  ram_dataOut
    );

    modport master (
        output cpu_req, cpu_wren, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output fft_req, fft_wren, fft_addr, fft_wdata, fft_lock,
        input  fft_gnt, fft_rvalid, fft_rdata,
        input  ram_wEn, ram_addr, ram_dataIn,
        output ram_dataOut
    );

endinterface

// File: rtl/dmem_arb_rr.sv
// rtl/dmem_arb_rr.sv - two-input round-robin grant with bounded FFT lock
//
// Ports:
//   clock, reset (async, active-low)
//   cpu_req, fft_req, fft_lock   requests and FFT lock request
//   cpu_gnt, fft_gnt             combinational grants for this cycle
module dmem_arb_rr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic cpu_req,
    input  logic fft_req,
    input  logic fft_lock,
    output logic cpu_gnt,
    output logic fft_gnt
);

    // lock_cnt is the number of cycles the FFT has held the lock so far,
    // counting the entry grant; release happens on the edge that would make
    // it reach MAX_LOCK, so the FFT gets at most MAX_LOCK back-to-back cycles.
    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST     = LOCK_CNT_W'(MAX_LOCK - 1);
    localparam bit                    LOCK_POSSIBLE = (MAX_LOCK > 1);

    logic [0:0]            state;
    logic                  last_winner;
    logic [LOCK_CNT_W-1:0] lock_cnt;

    always_comb begin
        cpu_gnt = 1'b0;
        fft_gnt = 1'b0;
        if (reset) begin
            if (state == ST_LOCK) begin
                fft_gnt = fft_req;
            end else if (cpu_req && fft_req) begin
                cpu_gnt = (last_winner == OWN_FFT);
                fft_gnt = (last_winner == OWN_CPU);
            end else begin
                cpu_gnt = cpu_req;
                fft_gnt = fft_req;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_ARB;
            last_winner <= OWN_FFT;
            lock_cnt    <= '0;
        end else if (state == ST_ARB) begin
            if (cpu_gnt) begin
                last_winner <= OWN_CPU;
            end
            if (fft_gnt) begin
                last_winner <= OWN_FFT;
            end
            if (fft_gnt && fft_lock && LOCK_POSSIBLE) begin
                state    <= ST_LOCK;
                lock_cnt <= LOCK_CNT_W'(1);
            end
        end else begin
            // Leaving with last_winner=FFT hands the next tie to a waiting CPU,
            // which also blocks an immediate re-lock.
            if (!fft_lock || lock_cnt == LOCK_LAST) begin
                state       <= ST_ARB;
                lock_cnt    <= '0;
                last_winner <= OWN_FFT;
            end else begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data RAM between CPU and FFT
//
// Ports:
//   clock  system clock
//   reset  asynchronous active-low reset
//   bus    dmem_arbiter_if.slave: CPU port, FFT port (with lock), RAM port
//   stat_cpu_grants/stat_fft_grants/stat_cpu_stall  saturating counters,
//          present only when DMEM_ARB_STATS_EN is defined
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]    stat_cpu_grants,
    output logic [31:0]    stat_fft_grants,
    output logic [31:0]    stat_cpu_stall
`endif
);

    logic              cpu_gnt;
    logic              fft_gnt;
    logic              mux_wen;
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_wdata;
    logic [DATA_W-1:0] ret_data;
    rd_tag_t           rd_tag;

    dmem_arb_rr #(
        .MAX_LOCK (MAX_LOCK)
    ) u_rr (
        .clock    (clock),
        .reset    (reset),
        .cpu_req  (bus.cpu_req),
        .fft_req  (bus.fft_req),
        .fft_lock (bus.fft_lock),
        .cpu_gnt  (cpu_gnt),
        .fft_gnt  (fft_gnt)
    );

    assign bus.cpu_gnt = cpu_gnt;
    assign bus.fft_gnt = fft_gnt;

    always_comb begin
        mux_wen   = 1'b0;
        mux_addr  = '0;
        mux_wdata = '0;
        if (cpu_gnt) begin
            mux_wen   = bus.cpu_wren;
            mux_addr  = bus.cpu_addr;
            mux_wdata = bus.cpu_wdata;
        end else if (fft_gnt) begin
            mux_wen   = bus.fft_wren;
            mux_addr  = bus.fft_addr;
            mux_wdata = bus.fft_wdata;
        end
    end

    assign bus.ram_wEn    = mux_wen;
    assign bus.ram_addr   = mux_addr;
    assign bus.ram_dataIn = mux_wdata;

    // The RAM answers one cycle after the address, so the owner of a granted
    // read is remembered for exactly one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_tag <= '0;
        end else begin
            rd_tag.valid <= (cpu_gnt && !bus.cpu_wren) || (fft_gnt && !bus.fft_wren);
            rd_tag.owner <= fft_gnt ? OWN_FFT : OWN_CPU;
        end
    end

    assign ret_data       = bus.ram_dataOut;
    assign bus.cpu_rvalid = rd_tag.valid && (rd_tag.owner == OWN_CPU);
    assign bus.fft_rvalid = rd_tag.valid && (rd_tag.owner == OWN_FFT);
    assign bus.cpu_rdata  = bus.cpu_rvalid ? ret_data : '0;
    assign bus.fft_rdata  = bus.fft_rvalid ? ret_data : '0;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_cpu_grants <= '0;
            stat_fft_grants <= '0;
            stat_cpu_stall  <= '0;
        end else begin
            if (cpu_gnt && stat_cpu_grants != '1) begin
                stat_cpu_grants <= stat_cpu_grants + 1'b1;
            end
            if (fft_gnt && stat_fft_grants != '1) begin
                stat_fft_grants <= stat_fft_grants + 1'b1;
            end
            if (bus.cpu_req && !cpu_gnt && stat_cpu_stall != '1) begin
                stat_cpu_stall <= stat_cpu_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int ML = 8;

    typedef struct {
        bit        cr, cw;
        bit [11:0] ca;
        bit [31:0] cd;
        bit        fr, fw;
        bit [11:0] fa;
        bit [31:0] fd;
        bit        fl;
    } stim_t;

    typedef struct {
        stim_t     s;
        bit        cg, fg, wen, crv, frv;
        bit [31:0] rd;
    } vec_t;

    typedef struct {
        bit        cg, fg, wen, crv, frv;
        bit [31:0] crd, frd;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] st_cg, st_fg, st_cs;
`endif

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_cpu_grants (st_cg),
        .stat_fft_grants (st_fg),
        .stat_cpu_stall  (st_cs)
`endif
    );

    // Synchronous-read RAM behind the arbiter.
    logic [DW-1:0] ram [0:4095];
    always @(posedge clk) begin
        if (bus.ram_wEn) ram[bus.ram_addr] <= bus.ram_dataIn;
        bus.ram_dataOut <= ram[bus.ram_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: abstract lock/priority bookkeeping and a shadow memory.
    bit        m_locked;
    int        m_held;
    bit        m_cpu_first;
    bit        m_rv, m_rv_fft, m_rv_known;
    bit [31:0] m_rv_data;
    bit [31:0] ref_mem   [0:4095];
    bit        ref_known [0:4095];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input bit cr, input bit cw, input bit [11:0] ca, input bit [31:0] cd,
                                 input bit fr, input bit fw, input bit [11:0] fa, input bit [31:0] fd,
                                 input bit fl);
        stim_t s;
        s.cr = cr; s.cw = cw; s.ca = ca; s.cd = cd;
        s.fr = fr; s.fw = fw; s.fa = fa; s.fd = fd; s.fl = fl;
        return s;
    endfunction

    function automatic vec_t vv(input stim_t s, input bit cg, input bit fg, input bit wen,
                                input bit crv, input bit frv, input bit [31:0] rd);
        vec_t v;
        v.s = s; v.cg = cg; v.fg = fg; v.wen = wen; v.crv = crv; v.frv = frv; v.rd = rd;
        return v;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_held = 0; m_cpu_first = 1; m_rv = 0;
    endtask

    task automatic model_grant(input stim_t s, output bit ec, output bit ef);
        if (m_locked) begin
            ec = 0; ef = s.fr;
        end else if (s.cr && s.fr) begin
            ec = m_cpu_first; ef = !m_cpu_first;
        end else begin
            ec = s.cr; ef = s.fr;
        end
    endtask

    task automatic model_access(input bit w, input bit [11:0] a, input bit [31:0] d, input bit is_fft);
        if (w) begin
            ref_mem[a] = d; ref_known[a] = 1;
        end else begin
            m_rv = 1; m_rv_fft = is_fft; m_rv_data = ref_mem[a]; m_rv_known = ref_known[a];
        end
    endtask

    task automatic model_update(input stim_t s, input bit ec, input bit ef);
        m_rv = 0;
        if (ec) begin m_cpu_first = 0; model_access(s.cw, s.ca, s.cd, 0); end
        if (ef) begin m_cpu_first = 1; model_access(s.fw, s.fa, s.fd, 1); end
        if (m_locked) begin
            m_held++;
            if (!s.fl || m_held >= ML) begin
                m_locked = 0; m_held = 0; m_cpu_first = 1;
            end
        end else if (ef && s.fl) begin
            if (ML > 1) begin m_locked = 1; m_held = 1; end
        end
    endtask

    task automatic drive(input stim_t s);
        bus.cpu_req = s.cr; bus.cpu_wren = s.cw; bus.cpu_addr = s.ca; bus.cpu_wdata = s.cd;
        bus.fft_req = s.fr; bus.fft_wren = s.fw; bus.fft_addr = s.fa; bus.fft_wdata = s.fd;
        bus.fft_lock = s.fl;
    endtask

    // Entered just after a rising edge; samples on the falling edge.
    task automatic cycle(input stim_t s, output obs_t o);
        bit        ec, ef;
        bit [31:0] e_crd, e_frd;
        drive(s);
        #4;
        model_grant(s, ec, ef);
        chk("cpu_gnt", bus.cpu_gnt, ec);
        chk("fft_gnt", bus.fft_gnt, ef);
        chk("ram_wEn", bus.ram_wEn, ec ? s.cw : (ef ? s.fw : 1'b0));
        if (ec || ef) begin
            chk("ram_addr", bus.ram_addr, ec ? s.ca : s.fa);
            if (ec ? s.cw : s.fw) chk("ram_dataIn", bus.ram_dataIn, ec ? s.cd : s.fd);
        end
        chk("cpu_rvalid", bus.cpu_rvalid, m_rv && !m_rv_fft);
        chk("fft_rvalid", bus.fft_rvalid, m_rv && m_rv_fft);
        e_crd = (m_rv && !m_rv_fft) ? m_rv_data : 32'h0;
        e_frd = (m_rv && m_rv_fft) ? m_rv_data : 32'h0;
        if (!(m_rv && !m_rv_fft && !m_rv_known)) chk("cpu_rdata", bus.cpu_rdata, e_crd);
        if (!(m_rv && m_rv_fft && !m_rv_known))  chk("fft_rdata", bus.fft_rdata, e_frd);
        o.cg = bus.cpu_gnt; o.fg = bus.fft_gnt; o.wen = bus.ram_wEn;
        o.crv = bus.cpu_rvalid; o.frv = bus.fft_rvalid;
        o.crd = bus.cpu_rdata; o.frd = bus.fft_rdata;
        @(posedge clk);
        model_update(s, ec, ef);
        #1;
    endtask

    vec_t  tbl [16];
    stim_t idle, s, prev, cpu_rd10, both_rd;
    obs_t  o;
    int    first_cpu, fft_before;
    bit    pc, pf;

    initial begin
        for (int i = 0; i < 4096; i++) begin ref_mem[i] = 0; ref_known[i] = 0; end
        idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cpu_rd10 = mk(1, 0, 12'h010, 0, 0, 0, 0, 0, 0);
        both_rd  = mk(1, 0, 12'h001, 0, 1, 0, 12'h002, 0, 0);

        tbl[0]  = vv(mk(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 0, 0, 0), 1, 0, 1, 0, 0, 0);
        tbl[1]  = vv(cpu_rd10, 1, 0, 0, 0, 0, 0);
        tbl[2]  = vv(idle, 0, 0, 0, 1, 0, 32'hDEADBEEF);
        tbl[3]  = vv(mk(1, 1, 12'h001, 32'h11111111, 0, 0, 0, 0, 0), 1, 0, 1, 0, 0, 0);
        tbl[4]  = vv(mk(0, 0, 0, 0, 1, 1, 12'h002, 32'h22222222, 0), 0, 1, 1, 0, 0, 0);
        tbl[5]  = vv(both_rd, 1, 0, 0, 0, 0, 0);
        tbl[6]  = vv(both_rd, 0, 1, 0, 1, 0, 32'h11111111);
        tbl[7]  = vv(both_rd, 1, 0, 0, 0, 1, 32'h22222222);
        tbl[8]  = vv(both_rd, 0, 1, 0, 1, 0, 32'h11111111);
        tbl[9]  = vv(cpu_rd10, 1, 0, 0, 0, 1, 32'h22222222);
        tbl[10] = vv(mk(1, 0, 12'h010, 0, 1, 0, 12'h002, 0, 1), 0, 1, 0, 1, 0, 32'hDEADBEEF);
        tbl[11] = vv(mk(1, 0, 12'h010, 0, 1, 0, 12'h001, 0, 1), 0, 1, 0, 0, 1, 32'h22222222);
        tbl[12] = vv(mk(1, 0, 12'h010, 0, 1, 1, 12'h003, 32'h33333333, 1), 0, 1, 1, 0, 1, 32'h11111111);
        tbl[13] = vv(mk(1, 0, 12'h010, 0, 1, 1, 12'h004, 32'h44444444, 0), 0, 1, 1, 0, 0, 0);
        tbl[14] = vv(cpu_rd10, 1, 0, 0, 0, 0, 0);
        tbl[15] = vv(idle, 0, 0, 0, 1, 0, 32'hDEADBEEF);

        // Reset state, with a CPU request present to show grants are held off.
        drive(mk(1, 1, 12'h123, 32'hCAFE0000, 1, 0, 12'h045, 0, 1));
        #1 rst_n = 1'b0;
        #11;
        chk("rst_cpu_gnt", bus.cpu_gnt, 0);
        chk("rst_fft_gnt", bus.fft_gnt, 0);
        chk("rst_ram_wEn", bus.ram_wEn, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_dataIn", bus.ram_dataIn, 0);
        chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("rst_fft_rvalid", bus.fft_rvalid, 0);
        chk("rst_fft_rdata", bus.fft_rdata, 0);
        drive(idle);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].s, o);
            chk($sformatf("tbl%0d_cpu_gnt", i), o.cg, tbl[i].cg);
            chk($sformatf("tbl%0d_fft_gnt", i), o.fg, tbl[i].fg);
            chk($sformatf("tbl%0d_wen", i), o.wen, tbl[i].wen);
            chk($sformatf("tbl%0d_cpu_rvalid", i), o.crv, tbl[i].crv);
            chk($sformatf("tbl%0d_fft_rvalid", i), o.frv, tbl[i].frv);
            if (tbl[i].crv) chk($sformatf("tbl%0d_cpu_rdata", i), o.crd, tbl[i].rd);
            if (tbl[i].frv) chk($sformatf("tbl%0d_fft_rdata", i), o.frd, tbl[i].rd);
        end

        // Forced release: both hold requests, FFT holds lock for 20 cycles.
        first_cpu = -1; fft_before = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(mk(1, 0, 12'h005, 0, 1, 0, 12'h006, 0, 1), o);
            if (o.cg && first_cpu < 0) first_cpu = i;
            if (o.fg && first_cpu < 0) fft_before++;
            if (i == 9) chk("relock_fft_gnt", o.fg, 1);
        end
        chk("maxlock_fft_grants", fft_before, ML);
        chk("maxlock_first_cpu_cycle", first_cpu, ML);

        // Reset pulsed while locked, right after a granted FFT read.
        cycle(mk(1, 0, 12'h010, 0, 1, 0, 12'h002, 0, 1), o);
        chk("prereset_fft_gnt", o.fg, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_fft_rvalid", bus.fft_rvalid, 0);
        chk("midreset_fft_gnt", bus.fft_gnt, 0);
        model_reset();
        #2 rst_n = 1'b1;
        drive(idle);
        @(posedge clk); #1;
        cycle(both_rd, o);
        chk("postreset_tie_cpu", o.cg, 1);
        chk("postreset_tie_fft", o.fg, 0);

`ifdef DMEM_ARB_STATS_EN
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        cycle(mk(0, 0, 0, 0, 1, 0, 12'h002, 0, 1), o);
        for (int i = 0; i < 5; i++) cycle(mk(1, 0, 12'h010, 0, 1, 0, 12'h002, 0, 1), o);
        cycle(mk(1, 0, 12'h010, 0, 1, 0, 12'h002, 0, 0), o);
        for (int i = 0; i < 10; i++) cycle(cpu_rd10, o);
        cycle(idle, o);
        chk("stat_cpu_stall", st_cs, 6);
        chk("stat_cpu_grants", st_cg, 10);
        chk("stat_fft_grants", st_fg, 7);
`endif

        // Randomised traffic over a small address window against the model.
        for (int a = 0; a < 16; a++) cycle(mk(1, 1, 12'(a), $urandom, 0, 0, 0, 0, 0), o);
        prev = idle; pc = 0; pf = 0;
        for (int i = 0; i < 400; i++) begin
            s = prev;
            if (!(prev.cr && !pc)) begin
                s.cr = ($urandom_range(0, 99) < 60);
                s.cw = 1'($urandom_range(0, 1));
                s.ca = 12'($urandom_range(0, 15));
                s.cd = $urandom;
            end
            if (!(prev.fr && !pf)) begin
                s.fr = ($urandom_range(0, 99) < 60);
                s.fw = 1'($urandom_range(0, 1));
                s.fa = 12'($urandom_range(0, 15));
                s.fd = $urandom;
                s.fl = ($urandom_range(0, 99) < 85);
            end
            cycle(s, o);
            pc = o.cg; pf = o.fg;
            prev = s;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
